// File: rtl/servo_pwm_decoder_pkg.sv
// Shared servo timing package: tick constants derived from the clock
// frequency, angle constants and the decoder state encoding.
package servo_pwm_decoder_pkg;

    localparam int unsigned LOCK   = 170;
    localparam int unsigned UNLOCK = 10;
    localparam int unsigned THRESH = 90;

    // Narrowest nominal pulse (1 ms)
    function automatic int unsigned min_ticks(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    // Widest nominal pulse (2 ms)
    function automatic int unsigned max_ticks(input int unsigned clk_hz);
        return 2 * min_ticks(clk_hz);
    endfunction

    function automatic int unsigned span_ticks(input int unsigned clk_hz);
        return max_ticks(clk_hz) - min_ticks(clk_hz);
    endfunction

    // Accept tolerance around the nominal window (100 us)
    function automatic int unsigned tol_ticks(input int unsigned clk_hz);
        return clk_hz / 10000;
    endfunction

    // One 50 Hz frame
    function automatic int unsigned period_ticks(input int unsigned clk_hz);
        return clk_hz / 50;
    endfunction

    // Two frames without a rising edge means the signal is gone
    function automatic int unsigned lost_ticks(input int unsigned clk_hz);
        return clk_hz / 25;
    endfunction

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2
    } dec_state_e;

endpackage

// File: rtl/servo_pwm_decoder_if.sv
// Servo PWM decoder bundle: the PWM line from the source plus the decoded
// results going back. The decoder is the slave, the PWM source the master.
interface servo_pwm_decoder_if;
    import servo_pwm_decoder_pkg::*;

    logic        pwm_in;
    logic [31:0] pulse_ticks;
    logic [7:0]  angle;
    logic        lock_out;
    logic        sample_valid;
    logic        pulse_err;
    logic        signal_lost;

    modport master (
        output pwm_in,
        input  pulse_ticks, angle, lock_out, sample_valid, pulse_err, signal_lost
    );

    modport slave (
        input  pwm_in,
        output pulse_ticks, angle, lock_out, sample_valid, pulse_err, signal_lost
    );

endinterface

// File: rtl/servo_pwm_decoder_sync_edge_detect.sv
// Two-flop synchronizer for the asynchronous PWM line plus a history flop,
// giving the synchronized level and single-cycle rise/fall indications.
module sync_edge_detect
    import servo_pwm_decoder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic s_cur,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic cur_q, cur_d;
    logic prev_q, prev_d;

    // Next values simply shift the input down the chain
    always_comb begin
        meta_d = async_in;
        cur_d  = meta_q;
        prev_d = cur_q;
    end

    // Synchronizer and history flops, cleared to a low line on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            cur_q  <= cur_d;
            prev_q <= prev_d;
        end
    end

    assign s_cur = cur_q;
    assign rise  = cur_q & ~prev_q;
    assign fall  = ~cur_q & prev_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures the high time of each pulse, converts it to an
// angle and lock state, flags malformed pulses and loss of signal.
module servo_pwm_decoder
    import servo_pwm_decoder_pkg::*;
#(
    parameter int unsigned CLK_HZ = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    servo_pwm_decoder_if.slave bus
);

    localparam logic [31:0] MIN_T  = 32'(min_ticks(CLK_HZ));
    localparam logic [31:0] MAX_T  = 32'(max_ticks(CLK_HZ));
    localparam logic [31:0] TOL_T  = 32'(tol_ticks(CLK_HZ));
    localparam logic [31:0] LOST_T = 32'(lost_ticks(CLK_HZ));
    localparam logic [31:0] ACC_LO = MIN_T - TOL_T;
    localparam logic [31:0] ACC_HI = MAX_T + TOL_T;
    localparam logic [31:0] SAT_T  = MAX_T + TOL_T + 32'd1;
    localparam logic [47:0] SPAN_W = 48'(span_ticks(CLK_HZ));
    localparam logic [47:0] HALF_W = 48'(span_ticks(CLK_HZ) / 2);
    localparam logic [7:0]  THRESH_A = 8'(THRESH);

    logic s_cur, rise, fall;

    sync_edge_detect u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.pwm_in),
        .s_cur    (s_cur),
        .rise     (rise),
        .fall     (fall)
    );

    dec_state_e  state_q, state_d;
    logic [1:0]  settle_q, settle_d;
    logic [31:0] width_q, width_d;
    logic [31:0] loss_q, loss_d;
    logic [31:0] pulse_ticks_q, pulse_ticks_d;
    logic [7:0]  angle_q, angle_d;
    logic        lock_q, lock_d;
    logic        sample_valid_q, sample_valid_d;
    logic        pulse_err_q, pulse_err_d;
    logic        signal_lost_q, signal_lost_d;
    logic [7:0]  angle_calc;
    logic        in_window;
    logic        loss_expire;

    // Width to angle with clamping; the 48-bit product cannot overflow
    always_comb begin
        angle_calc = 8'd0;
        if (width_q <= MIN_T) begin
            angle_calc = 8'd0;
        end else if (width_q >= MAX_T) begin
            angle_calc = 8'd180;
        end else begin
            angle_calc = 8'(((48'(width_q - MIN_T) * 48'd180) + HALF_W) / SPAN_W);
        end
    end

    // Next-state logic for the FSM, width counter, loss timer and outputs.
    // The synchronizer resets to a low line, so right after reset it can
    // show a false rise on a pulse already in progress; WAIT_LOW only trusts
    // s_cur once the settle counter shows the chain holds real samples.
    always_comb begin
        state_d        = state_q;
        settle_d       = settle_q;
        width_d        = width_q;
        loss_d         = loss_q;
        pulse_ticks_d  = pulse_ticks_q;
        angle_d        = angle_q;
        lock_d         = lock_q;
        sample_valid_d = 1'b0;
        pulse_err_d    = 1'b0;
        signal_lost_d  = signal_lost_q;
        in_window      = (width_q >= ACC_LO) && (width_q <= ACC_HI);
        loss_expire    = !rise && (loss_q == LOST_T - 32'd1);

        if (settle_q != 2'd2) begin
            settle_d = settle_q + 2'd1;
        end

        if (rise) begin
            loss_d = 32'd0;
        end else if (loss_q != LOST_T) begin
            loss_d = loss_q + 32'd1;
        end

        if (loss_expire) begin
            signal_lost_d = 1'b1;
        end

        case (state_q)
            WAIT_LOW: begin
                if (settle_q == 2'd2 && !s_cur) begin
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    width_d = 32'd1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = WAIT_RISE;
                    if (in_window) begin
                        pulse_ticks_d  = width_q;
                        angle_d        = angle_calc;
                        lock_d         = (angle_calc >= THRESH_A);
                        sample_valid_d = 1'b1;
                        signal_lost_d  = 1'b0;
                    end else begin
                        pulse_err_d = 1'b1;
                    end
                end else if (width_q != SAT_T) begin
                    width_d = width_q + 32'd1;
                end
            end
            default: begin
                state_d = WAIT_LOW;
            end
        endcase
    end

    // State and output registers; reset returns everything to idle values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= WAIT_LOW;
            settle_q       <= 2'd0;
            width_q        <= 32'd0;
            loss_q         <= 32'd0;
            pulse_ticks_q  <= 32'd0;
            angle_q        <= 8'd0;
            lock_q         <= 1'b1;
            sample_valid_q <= 1'b0;
            pulse_err_q    <= 1'b0;
            signal_lost_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            width_q        <= width_d;
            loss_q         <= loss_d;
            pulse_ticks_q  <= pulse_ticks_d;
            angle_q        <= angle_d;
            lock_q         <= lock_d;
            sample_valid_q <= sample_valid_d;
            pulse_err_q    <= pulse_err_d;
            signal_lost_q  <= signal_lost_d;
        end
    end

    assign bus.pulse_ticks  = pulse_ticks_q;
    assign bus.angle        = angle_q;
    assign bus.lock_out     = lock_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.pulse_err    = pulse_err_q;
    assign bus.signal_lost  = signal_lost_q;

endmodule

// File: doc/servo_pwm_decoder.md
# servo_pwm_decoder

Measures an incoming hobby-servo PWM signal (50 Hz frame, 1–2 ms high pulse) and recovers the commanded angle and lock state. It is the receive-side counterpart of the lock servo driver. It sits in the door controller to check the servo command line (loopback/self-test) or to accept lock commands from an external servo-style source. It also flags malformed pulses and loss of signal.

## Interface
- `CLK_HZ`, default 25_000_000: clock frequency in Hz; all tick constants derive from it.
- `clk` in 1: system clock.
- `rst` in 1: reset. **Asynchronous and active-high, one clock domain.**
- `pwm_in` in 1: servo PWM input, asynchronous to `clk`.
- `pulse_ticks` out 32: last accepted high-pulse width in `clk` cycles. Reset 0.
- `angle` out 8: decoded angle, 0–180. Reset 0.
- `lock_out` out 1: 1 = locked (`angle` ≥ 90). Reset 1.
- `sample_valid` out 1: one-cycle strobe when a pulse is accepted. Reset 0.
- `pulse_err` out 1: one-cycle strobe when a pulse is rejected. Reset 0.
- `signal_lost` out 1: level; no rising edge for `LOST_TICKS`. Reset 1.

## Operation
- **Constants:**
  - `MIN_TICKS` = CLK_HZ/1000
  - `MAX_TICKS` = 2·MIN_TICKS
  - `SPAN` = MAX_TICKS − MIN_TICKS
  - `TOL_TICKS` = CLK_HZ/10000 (100 µs)
  - `LOST_TICKS` = CLK_HZ/25 (2 frames)
- **Input conditioning:** 2-flop synchronizer gives `s_cur`, plus a third flop gives `s_prev`.
  - `rise` = `s_cur` & ~`s_prev`
  - `fall` = ~`s_cur` & `s_prev`
- **FSM states:**
  - `WAIT_LOW`: the reset state. Ignores any pulse already in progress. Goes to `WAIT_RISE` when `s_cur` = 0.
  - `WAIT_RISE`: on `rise`, set width counter to 1 and go to `HIGH`.
  - `HIGH`: width counter increments each cycle, saturating at MAX_TICKS+TOL_TICKS+1. On `fall`, evaluate the pulse and go to `WAIT_RISE`.
- **Evaluation (on `fall`):**
  - Accept window: MIN_TICKS−TOL_TICKS ≤ width ≤ MAX_TICKS+TOL_TICKS.
  - **Accepted:**
    - `pulse_ticks` ← width.
    - `angle` ← clamp:
      - width ≤ MIN_TICKS → 0
      - width ≥ MAX_TICKS → 180
      - otherwise ((width−MIN_TICKS)·180 + SPAN/2) / SPAN, i.e. round-to-nearest.
    - `lock_out` ← (angle ≥ 90).
    - `sample_valid` pulses for one cycle.
    - `signal_lost` clears.
  - **Rejected:** `pulse_err` pulses for one cycle. `pulse_ticks`, `angle` and `lock_out` hold.
- **Arithmetic width:** the intermediate product uses ≥ 48 bits. Division is by a constant and is combinational, feeding the output register.
- **Loss timer:**
  - Counts cycles since the last `rise`, saturating, and resets to 0 on `rise`.
  - When it reaches LOST_TICKS, `signal_lost` ← 1.
  - `signal_lost` is cleared only by an accepted pulse.
  - Held outputs keep their last values while the signal is lost.
- **Simultaneous events:** an accepted sample in the same cycle the loss timer expires leaves `signal_lost` at 0; the accept wins.
- **Reset mid-pulse:** all outputs go to their reset values and the FSM enters `WAIT_LOW`. The truncated pulse never produces `sample_valid` or `pulse_err`.

## Timing
- If `pwm_in` changes before clk edge k, then `s_cur` updates at k+1 and `rise`/`fall` are true during the cycle after k+1.
- Result outputs (`pulse_ticks`, `angle`, `lock_out`, `sample_valid`/`pulse_err`) register at edge k+2. Latency from the input falling edge is 3 clocks.
- Measured width equals the true high time in cycles ±1.
- `sample_valid` and `pulse_err` are never high together, and are never high on consecutive cycles.
- `signal_lost` asserts on the cycle the loss counter reaches LOST_TICKS.

## Structure
- A shared servo package holds:
  - MIN_TICKS, MAX_TICKS, SPAN, TOL_TICKS, PERIOD_TICKS, LOST_TICKS, as functions of CLK_HZ.
  - Angle constants LOCK = 170, UNLOCK = 10, THRESH = 90.
  - These are shared with the servo driver.
- One sub-module: `sync_edge_detect`, the 2-flop synchronizer plus `s_prev` flop, with `rise`/`fall` outputs and reset to 0.
- FSM, width counter, loss timer and angle conversion live in the top module.

## Test plan
1. **Nominal pulse:** after reset, 1.5 ms high / 20 ms frames (37500 high ticks at 25 MHz) → one `sample_valid` per frame; `pulse_ticks` = 37500±1; `angle` = 90; `lock_out` = 1; `signal_lost` 0 after the first accept.
2. **Loopback with servo driver:** lock=1 (48611 ticks) → `angle` 170, `lock_out` 1. Then lock=0 (26388 ticks) → `angle` 10, `lock_out` 0 after the first complete pulse.
3. **Reject then clamp:**
   - 0.5 ms pulse (12500 ticks) → `pulse_err` for one cycle; `angle`/`lock_out` unchanged.
   - 2.05 ms pulse (51250 ticks) → accepted, `angle` = 180.
   - 2.2 ms pulse (55000 ticks) → `pulse_err`.
4. **Signal loss:** hold `pwm_in` low for 1,000,000 cycles → `signal_lost` rises at that cycle, `angle` holds. The next 1 ms pulse → `angle` 0 and `signal_lost` clears.
5. **Reset mid-pulse:** assert `rst` 10000 cycles into a high pulse and release while still high → all outputs at reset values; no strobe for the partial pulse; the first strobe comes after the next full pulse.
6. **Stuck high:** `pwm_in` high for 2,000,000 cycles → `signal_lost` = 1, width saturates. The falling edge → `pulse_err`, outputs held.
